// File: rtl/response_returner.sv
// Read-response reorder buffer: stores out-of-order read completions per index and releases
// them in allocation order over valid/ready; write completions become one-cycle ack pulses.
package response_returner_pkg;
   typedef enum logic {READ = 1'b0, WRITE = 1'b1} r_type;
endpackage

module response_returner
   import response_returner_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ENTRIES = 64,
   parameter int IDX     = $clog2(ENTRIES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alloc_req,
   output logic              alloc_gnt,
   output logic [IDX-1:0]    alloc_idx,
   input  logic              ret_valid,
   input  r_type             ret_type,
   input  logic [DATA_W-1:0] ret_data,
   input  logic [IDX-1:0]    ret_index,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [IDX-1:0]    rsp_index,
   output logic              wr_ack,
   output logic [IDX:0]      outstanding,
   output logic              err_spurious
);
   localparam logic [IDX:0] FULL = (IDX+1)'(ENTRIES);

   logic [DATA_W-1:0]  ram [ENTRIES];
   logic [ENTRIES-1:0] alloc_bits;
   logic [ENTRIES-1:0] filled_bits;
   logic [ENTRIES-1:0] pop_mask;
   logic [ENTRIES-1:0] set_alloc;
   logic [ENTRIES-1:0] set_fill;
   logic [IDX-1:0]     head;
   logic [IDX-1:0]     tail;
   logic [IDX:0]       count;
   logic               do_alloc;
   logic               do_pop;
   logic               rd_ret;
   logic               rd_ok;

   assign alloc_gnt   = (count != FULL);
   assign alloc_idx   = tail;
   assign rsp_valid   = filled_bits[head];
   assign rsp_data    = ram[head];
   assign rsp_index   = head;
   assign outstanding = count;

   assign do_alloc = alloc_req && alloc_gnt;
   assign do_pop   = rsp_valid && rsp_ready;
   assign rd_ret   = ret_valid && (ret_type == READ);
   // A read is only legal for an index that is allocated and still waiting for its data.
   assign rd_ok    = alloc_bits[ret_index] && !filled_bits[ret_index];

   always_comb begin
      pop_mask  = '0;
      set_alloc = '0;
      set_fill  = '0;
      if (do_pop)
         pop_mask[head] = 1'b1;
      if (do_alloc)
         set_alloc[tail] = 1'b1;
      if (rd_ret && rd_ok)
         set_fill[ret_index] = 1'b1;
   end

   // Data storage needs no reset: filled_bits gates every use of it.
   always_ff @(posedge clk) begin
      if (rd_ret && rd_ok)
         ram[ret_index] <= ret_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         alloc_bits   <= '0;
         filled_bits  <= '0;
         wr_ack       <= 1'b0;
         err_spurious <= 1'b0;
      end else begin
         alloc_bits  <= (alloc_bits & ~pop_mask) | set_alloc;
         filled_bits <= (filled_bits & ~pop_mask) | set_fill;
         if (do_alloc)
            tail <= tail + IDX'(1);
         if (do_pop)
            head <= head + IDX'(1);
         case ({do_alloc, do_pop})
            2'b10:   count <= count + (IDX+1)'(1);
            2'b01:   count <= count - (IDX+1)'(1);
            default: count <= count;
         endcase
         wr_ack       <= ret_valid && (ret_type == WRITE);
         err_spurious <= err_spurious || (rd_ret && !rd_ok);
      end
   end
endmodule

// File: tb/tb_response_returner.sv
// Bench for response_returner: vector table, hand sequences and an in-order scoreboard model.
module tb_response_returner;
   import response_returner_pkg::*;

   localparam int DW = 16;
   localparam int N  = 64;
   localparam int IW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          alloc_req;
   logic          alloc_gnt;
   logic [IW-1:0] alloc_idx;
   logic          ret_valid;
   r_type         ret_type;
   logic [DW-1:0] ret_data;
   logic [IW-1:0] ret_index;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic [IW-1:0] rsp_index;
   logic          wr_ack;
   logic [IW:0]   outstanding;
   logic          err_spurious;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   response_returner #(.DATA_W(DW), .ENTRIES(N), .IDX(IW)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
      .ret_valid(ret_valid), .ret_type(ret_type), .ret_data(ret_data), .ret_index(ret_index),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_index(rsp_index),
      .wr_ack(wr_ack), .outstanding(outstanding), .err_spurious(err_spurious)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model; the queue holds allocated indices in allocation order.
   logic [N-1:0]  m_alloc;
   logic [N-1:0]  m_filled;
   logic [DW-1:0] m_data [N];
   logic [IW-1:0] m_tail;
   int            m_count;
   logic          m_err;
   logic          m_ack;
   logic [IW-1:0] sb_q [$];

   always @(negedge clk) begin : mon
      logic          exp_rv, pop_ev, alloc_ev, rd_ev, accept;
      logic [IW-1:0] h;
      if (!rst_n) begin
         sb_q.delete();
         m_alloc  = '0;
         m_filled = '0;
         m_tail   = '0;
         m_count  = 0;
         m_err    = 1'b0;
         m_ack    = 1'b0;
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_alloc_gnt", alloc_gnt, 1);
         chk("rst_outstanding", outstanding, 0);
         chk("rst_wr_ack", wr_ack, 0);
         chk("rst_err", err_spurious, 0);
      end else begin
         exp_rv = (sb_q.size() != 0) && m_filled[sb_q[0]];
         chk("mon_rsp_valid", rsp_valid, exp_rv);
         chk("mon_alloc_gnt", alloc_gnt, (m_count != N));
         chk("mon_alloc_idx", alloc_idx, m_tail);
         chk("mon_outstanding", outstanding, m_count);
         chk("mon_wr_ack", wr_ack, m_ack);
         chk("mon_err", err_spurious, m_err);
         pop_ev   = exp_rv && rsp_ready;
         alloc_ev = alloc_req && (m_count != N);
         rd_ev    = ret_valid && (ret_type == READ);
         accept   = m_alloc[ret_index] && !m_filled[ret_index];
         if (pop_ev) begin
            h = sb_q.pop_front();
            chk("sb_rsp_index", rsp_index, h);
            chk("sb_rsp_data", rsp_data, m_data[h]);
            m_alloc[h]  = 1'b0;
            m_filled[h] = 1'b0;
         end
         if (rd_ev) begin
            if (accept) begin
               m_filled[ret_index] = 1'b1;
               m_data[ret_index]   = ret_data;
            end else begin
               m_err = 1'b1;
            end
         end
         if (alloc_ev) begin
            m_alloc[m_tail] = 1'b1;
            sb_q.push_back(m_tail);
            m_tail = m_tail + 6'd1;
         end
         m_count = m_count + (alloc_ev ? 1 : 0) - (pop_ev ? 1 : 0);
         m_ack   = ret_valid && (ret_type == WRITE);
      end
   end

   typedef struct {
      bit          rst;
      bit          areq;
      bit          rv;
      bit          rt;
      logic [15:0] rd;
      logic [5:0]  ri;
      bit          rr;
      bit          e_rv;
      logic [5:0]  e_ri;
      logic [15:0] e_rd;
      bit          e_ack;
      int          e_out;
      logic [5:0]  e_aidx;
   } vec_t;

   vec_t vt [$];

   function automatic vec_t mk(bit rst, bit areq, bit rv, bit rt, logic [15:0] rd, logic [5:0] ri,
                               bit rr, bit e_rv, logic [5:0] e_ri, logic [15:0] e_rd, bit e_ack,
                               int e_out, logic [5:0] e_aidx);
      vec_t v;
      v.rst = rst; v.areq = areq; v.rv = rv; v.rt = rt; v.rd = rd; v.ri = ri; v.rr = rr;
      v.e_rv = e_rv; v.e_ri = e_ri; v.e_rd = e_rd; v.e_ack = e_ack; v.e_out = e_out;
      v.e_aidx = e_aidx;
      return v;
   endfunction

   task automatic drive(input bit areq, input bit rv, input bit rt, input logic [15:0] rd,
                        input logic [5:0] ri, input bit rr);
      alloc_req = areq;
      ret_valid = rv;
      ret_type  = r_type'(rt);
      ret_data  = rd;
      ret_index = ri;
      rsp_ready = rr;
   endtask

   task automatic cyc(input bit areq, input bit rv, input bit rt, input logic [15:0] rd,
                      input logic [5:0] ri, input bit rr);
      @(posedge clk);
      #1;
      drive(areq, rv, rt, rd, ri, rr);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      drive(0, 0, 0, 16'h0, 6'd0, 1);
      rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      drive(0, 0, 0, 16'h0, 6'd0, 1);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // in-order read, out-of-order reads, back-to-back writes
      vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
      vt.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 1, 1));
      vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 1, 1));
      vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 1, 1));
      vt.push_back(mk(0, 0, 1, 0, 16'hA5A5, 0, 1, 0, 0, 16'h0000, 0, 1, 1));
      vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 16'hA5A5, 0, 1, 1));
      vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 1));
      vt.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 0));
      vt.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 1, 1));
      vt.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 2, 2));
      vt.push_back(mk(0, 0, 1, 0, 16'h0002, 2, 1, 0, 0, 16'h0000, 0, 3, 3));
      vt.push_back(mk(0, 0, 1, 0, 16'h0001, 1, 1, 0, 0, 16'h0000, 0, 3, 3));
      vt.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 3, 3));
      vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 16'h0000, 0, 3, 3));
      vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h0001, 0, 2, 3));
      vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 1, 2, 16'h0002, 0, 1, 3));
      vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 3));
      vt.push_back(mk(0, 0, 1, 1, 16'hFFFF, 5, 1, 0, 0, 16'h0000, 0, 0, 3));
      vt.push_back(mk(0, 0, 1, 1, 16'hFFFF, 5, 1, 0, 0, 16'h0000, 1, 0, 3));
      vt.push_back(mk(0, 0, 1, 1, 16'hFFFF, 5, 1, 0, 0, 16'h0000, 1, 0, 3));
      vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 1, 0, 3));
      vt.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 3));

      foreach (vt[i]) begin
         if (vt[i].rst)
            apply_reset();
         cyc(vt[i].areq, vt[i].rv, vt[i].rt, vt[i].rd, vt[i].ri, vt[i].rr);
         chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, vt[i].e_rv);
         if (vt[i].e_rv) begin
            chk($sformatf("vec%0d_rsp_index", i), rsp_index, vt[i].e_ri);
            chk($sformatf("vec%0d_rsp_data", i), rsp_data, vt[i].e_rd);
         end
         chk($sformatf("vec%0d_wr_ack", i), wr_ack, vt[i].e_ack);
         chk($sformatf("vec%0d_outstanding", i), outstanding, vt[i].e_out);
         chk($sformatf("vec%0d_alloc_idx", i), alloc_idx, vt[i].e_aidx);
      end

      // backpressure: response must hold while rsp_ready is low
      apply_reset();
      cyc(1, 0, 0, 16'h0, 6'd0, 0);
      cyc(0, 1, 0, 16'h1234, 6'd0, 0);
      for (int k = 0; k < 5; k++) begin
         cyc(0, 0, 0, 16'h0, 6'd0, 0);
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_index", rsp_index, 0);
         chk("bp_rsp_data", rsp_data, 16'h1234);
      end
      cyc(0, 0, 0, 16'h0, 6'd0, 1);
      chk("bp_pop_valid", rsp_valid, 1);
      cyc(0, 0, 0, 16'h0, 6'd0, 1);
      chk("bp_after_valid", rsp_valid, 0);
      chk("bp_after_outstanding", outstanding, 0);

      // spurious return to unallocated index, then a duplicate return
      cyc(0, 1, 0, 16'hDEAD, 6'd9, 1);
      chk("err_before", err_spurious, 0);
      cyc(0, 0, 0, 16'h0, 6'd0, 1);
      chk("err_set", err_spurious, 1);
      chk("err_outstanding", outstanding, 0);
      chk("err_rsp_valid", rsp_valid, 0);
      cyc(1, 0, 0, 16'h0, 6'd0, 0);
      chk("dup_alloc_idx", alloc_idx, 1);
      cyc(0, 1, 0, 16'h1111, 6'd1, 0);
      cyc(0, 1, 0, 16'h2222, 6'd1, 0);
      chk("dup_first_data", rsp_data, 16'h1111);
      cyc(0, 0, 0, 16'h0, 6'd0, 0);
      chk("dup_kept_data", rsp_data, 16'h1111);
      chk("dup_kept_valid", rsp_valid, 1);
      cyc(0, 0, 0, 16'h0, 6'd0, 1);
      cyc(0, 0, 0, 16'h0, 6'd0, 1);
      chk("dup_drained", outstanding, 0);
      chk("err_sticky", err_spurious, 1);

      // fill to capacity, then wrap the tail
      apply_reset();
      for (int k = 0; k < N; k++)
         cyc(1, 0, 0, 16'h0, 6'd0, 1);
      cyc(1, 0, 0, 16'h0, 6'd0, 1);
      chk("full_gnt", alloc_gnt, 0);
      chk("full_outstanding", outstanding, 64);
      cyc(0, 1, 0, 16'hBEEF, 6'd0, 1);
      chk("full_gnt_hold", alloc_gnt, 0);
      cyc(0, 0, 0, 16'h0, 6'd0, 1);
      chk("full_pop_valid", rsp_valid, 1);
      chk("full_pop_data", rsp_data, 16'hBEEF);
      cyc(0, 0, 0, 16'h0, 6'd0, 1);
      chk("wrap_gnt", alloc_gnt, 1);
      chk("wrap_alloc_idx", alloc_idx, 0);
      chk("wrap_outstanding", outstanding, 63);
      cyc(1, 0, 0, 16'h0, 6'd0, 1);
      cyc(0, 0, 0, 16'h0, 6'd0, 1);
      chk("wrap_refull", outstanding, 64);

      // random traffic, checked by the scoreboard model
      for (int c = 0; c < 200; c++) begin
         bit            a, rv, rt, rr;
         logic [15:0]   d;
         logic [IW-1:0] ri, cand;
         int            kind, st;
         @(posedge clk);
         #1;
         a    = ($urandom_range(0, 1) == 1);
         rr   = ($urandom_range(0, 3) != 0);
         rv   = 1'b0;
         rt   = 1'b0;
         ri   = '0;
         d    = 16'($urandom);
         kind = $urandom_range(0, 9);
         if (kind < 6) begin
            st = $urandom_range(0, N - 1);
            for (int j = 0; j < N; j++) begin
               cand = 6'(st + j);
               if (m_alloc[cand] && !m_filled[cand]) begin
                  rv = 1'b1;
                  ri = cand;
                  break;
               end
            end
         end else if (kind == 6) begin
            rv = 1'b1;
            rt = 1'b1;
         end
         drive(a, rv, rt, d, ri, rr);
         @(negedge clk);
      end

      // reset in the middle of traffic discards everything in flight
      cyc(1, 0, 0, 16'h0, 6'd0, 0);
      cyc(1, 0, 0, 16'h0, 6'd0, 0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_outstanding", outstanding, 0);
      chk("midrst_alloc_idx", alloc_idx, 0);
      drive(0, 0, 0, 16'h0, 6'd0, 1);
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 16'h0, 6'd0, 1);
         chk("postrst_rsp_valid", rsp_valid, 0);
      end
      cyc(1, 0, 0, 16'h0, 6'd0, 1);
      chk("postrst_alloc_idx", alloc_idx, 0);
      cyc(0, 1, 0, 16'h5A5A, 6'd0, 1);
      cyc(0, 0, 0, 16'h0, 6'd0, 1);
      chk("postrst_rsp_valid_new", rsp_valid, 1);
      chk("postrst_rsp_data", rsp_data, 16'h5A5A);
      cyc(0, 0, 0, 16'h0, 6'd0, 1);
      chk("postrst_drained", outstanding, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/response_returner.md
# response_returner

Read-response reorder buffer and write-acknowledge generator, sitting between the memory-controller back end and the front-end requesters. The front end allocates a read index per read request before issue. The back end completes reads out of order on its returner_* outputs. This block stores the read data per index and releases it to the requester strictly in allocation order over a valid/ready handshake. Write completions become single-cycle acknowledge pulses.

## Interface
Parameters:
- DATA_W, 16, width of read data (matches back-end data_width)
- ENTRIES, 64, number of read indices (power of two)
- IDX, $clog2(ENTRIES) = 6, index width (matches read_entries_log)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alloc_req  in  1  front end requests a read index
- alloc_gnt  out  1  index available; high when count < ENTRIES
- alloc_idx  out  IDX  index granted this cycle (tail pointer)
- ret_valid  in  1  back-end completion valid (returner_valid)
- ret_type  in  r_type  READ or WRITE (returner_type)
- ret_data  in  DATA_W  read data (returner_data)
- ret_index  in  IDX  completed read index (returner_index)
- rsp_valid  out  1  in-order read response valid
- rsp_ready  in  1  requester accepts response
- rsp_data  out  DATA_W  response data
- rsp_index  out  IDX  index of response
- wr_ack  out  1  one-cycle pulse per write completion
- outstanding  out  IDX+1  allocated, not yet popped entries
- err_spurious  out  1  sticky protocol-error flag

## Operation
- State: data RAM ENTRIES x DATA_W; per-entry alloc and filled bits; head and tail pointers, IDX bits each, wrapping modulo ENTRIES; count, IDX+1 bits.
- Allocate: fires when alloc_req && alloc_gnt.
  - Set alloc[tail].
  - tail <= tail+1, wrapping at ENTRIES-1 -> 0.
  - count increments.
- Read return: fires when ret_valid && ret_type==READ.
  - Accepted only if alloc[ret_index]=1 and filled[ret_index]=0.
  - On accept, write ret_data to RAM[ret_index] and set filled.
  - Otherwise drop the return and set err_spurious. It stays set until reset.
- Write return: fires when ret_valid && ret_type==WRITE.
  - Assert wr_ack for exactly one cycle.
  - Buffer state is unchanged; ret_index and ret_data are ignored.
- Response outputs:
  - rsp_valid = filled[head].
  - rsp_data = RAM[head], rsp_index = head.
- Pop: fires when rsp_valid && rsp_ready.
  - Clear alloc[head] and filled[head].
  - head <= head+1, wrapping.
  - count decrements.
- Simultaneous events:
  - Allocate and pop in the same cycle leave count unchanged.
  - Allocate while full is impossible, because alloc_gnt is low.
  - A read return to the head entry can never coincide with a pop of that entry, since the entry is not yet filled.
  - A read return to a different entry during a pop is independent.
- outstanding = count.

## Timing
- Reset (async assert, sync release) clears:
  - head, tail and count to 0;
  - all alloc and filled bits;
  - rsp_valid, wr_ack and err_spurious to 0.
- After reset: alloc_gnt=1, alloc_idx=0, outstanding=0. RAM contents are don't-care.
- Reset asserted mid-operation discards all in-flight entries. No response is issued for them.
- Allocation takes effect at the edge where it fires. The next alloc_idx is visible in the following cycle.
- Read return captured at the edge ending cycle N: if ret_index==head, rsp_valid is high in cycle N+1 (1-cycle latency).
- rsp_valid, rsp_data and rsp_index hold stable while rsp_valid && !rsp_ready.
- After a pop at edge N, the new head's response can be valid in cycle N+1 if that entry is already filled. Full throughput is one response per cycle.
- Write return in cycle N gives wr_ack high in cycle N+1 only. Back-to-back write returns give back-to-back pulses.
- Full boundary: count==ENTRIES drives alloc_gnt low in the same cycle. It returns high the cycle after a pop.

## Test plan
- Reset then idle -> alloc_gnt=1, alloc_idx=0, rsp_valid=0, wr_ack=0, outstanding=0, err_spurious=0.
- In-order read:
  - Stimulus: allocate idx 0; 3 cycles later READ return idx 0 with data 0xA5A5; rsp_ready=1.
  - Response: rsp_valid for exactly 1 cycle, one cycle after the return, with rsp_data=0xA5A5 and rsp_index=0; outstanding returns to 0.
- Out-of-order read:
  - Stimulus: allocate 0,1,2; return 2 (0x0002), then 1 (0x0001), then 0 (0x0000).
  - Response: no rsp_valid until idx 0 returns, then responses 0,1,2 on consecutive cycles with matching data.
- Full and wrap:
  - Stimulus: allocate 64 with no returns.
  - Response: alloc_gnt low and outstanding=64.
  - Stimulus: return and pop idx 0, then allocate again.
  - Response: alloc_idx=0 (wrap); continue 200 random alloc/return/pop cycles against an in-order scoreboard.
- Backpressure: with idx 0 filled and rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_index stable throughout; a single pop occurs when rsp_ready rises.
- Writes and errors:
  - Stimulus: WRITE returns on 3 consecutive cycles.
  - Response: 3 consecutive wr_ack pulses.
  - Stimulus: READ return to unallocated idx 9.
  - Response: err_spurious sets and stays high; buffer state is unchanged.
  - Stimulus: duplicate READ return to a filled idx.
  - Response: dropped, and the original data is preserved.
